// File: rtl/ipu_result_tx.sv
// ipu_result_tx: buffers 8-bit IPU results and returns them to the host as UART frames.
// Define IPU_TX_PARITY_EN for 8E1 frames; the default build sends 8N1.
module ipu_result_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] C,
    input  logic       Valid,
    output logic       Ready,
    input  logic       OvfClr,
    output logic       Overflow,
    output logic       Busy,
    output logic       Tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

`ifdef IPU_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t state, next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          ready_q, ovf_q;
    logic [15:0]   baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_q;
    logic          wr, pop, not_empty, bit_done;

    assign wr        = Valid && ready_q;
    assign not_empty = (count != '0);
    assign bit_done  = (baud == LAST);
    assign count_nxt = count + CW'(wr) - CW'(pop);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        pop  = 1'b0;
        unique case (state)
            IDLE: begin
                if (not_empty) begin
                    next = START;
                    pop  = 1'b1;
                end
            end
            START: if (bit_done) next = DATA;
            DATA: begin
                if (bit_done && bit_idx == 3'd7) begin
`ifdef IPU_TX_PARITY_EN
                    next = PARITY;
`else
                    next = STOP;
`endif
                end
            end
`ifdef IPU_TX_PARITY_EN
            PARITY: if (bit_done) next = STOP;
`endif
            STOP: begin
                // back-to-back frames restart without an idle gap
                if (bit_done) begin
                    if (not_empty) begin
                        next = START;
                        pop  = 1'b1;
                    end else begin
                        next = IDLE;
                    end
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (wr) mem[wr_ptr] <= C;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nxt;
            ready_q <= (count_nxt != FULL);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                  ovf_q <= 1'b0;
        else if (OvfClr)             ovf_q <= 1'b0;
        else if (Valid && !ready_q)  ovf_q <= 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
        end else begin
            if (state == IDLE || bit_done) baud <= '0;
            else                           baud <= baud + 16'd1;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                par_q   <= ^mem[rd_ptr];
                bit_idx <= '0;
            end else if (state == DATA && bit_done) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        Tx = 1'b1;
        unique case (state)
            START:   Tx = 1'b0;
            DATA:    Tx = shreg[0];
`ifdef IPU_TX_PARITY_EN
            PARITY:  Tx = par_q;
`endif
            default: Tx = 1'b1;
        endcase
    end

`ifndef IPU_TX_PARITY_EN
    logic unused_par;
    assign unused_par = par_q;
`endif

    assign Ready    = ready_q;
    assign Overflow = ovf_q;
    assign Busy     = (state != IDLE) || not_empty;

endmodule

// File: tb/tb_ipu_result_tx.sv
// tb_ipu_result_tx: scoreboard bench; a UART receiver model checks every frame on Tx.
// Build with IPU_TX_PARITY_EN to check 8E1 frames.
module tb_ipu_result_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef IPU_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = CPB * NBITS;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [7:0] C = 8'h00;
    logic       Valid = 1'b0;
    logic       OvfClr = 1'b0;
    logic       Ready, Overflow, Busy, Tx;

    ipu_result_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .C(C), .Valid(Valid), .Ready(Ready),
        .OvfClr(OvfClr), .Overflow(Overflow), .Busy(Busy), .Tx(Tx)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [7:0] sb[$];
    int starts[$];

    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_bits(input int n, inout bit ok);
        repeat (n) begin
            @(negedge Clk);
            if (!Rst_n) ok = 1'b0;
        end
    endtask

    // receiver model: samples each bit in its middle, compares with the oldest accepted byte
    initial begin : monitor
        logic [7:0] d;
        bit ok;
        int st;
        forever begin
            @(negedge Clk);
            if (Rst_n && Tx === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                d = 8'h00;
                wait_bits(CPB / 2, ok);
                if (!ok) continue;
                check("start bit", {31'd0, Tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    wait_bits(CPB, ok);
                    d[i] = Tx;
                end
                if (!ok) continue;
`ifdef IPU_TX_PARITY_EN
                wait_bits(CPB, ok);
                if (!ok) continue;
                check("parity bit", {31'd0, Tx}, {31'd0, ^d});
`endif
                wait_bits(CPB, ok);
                if (!ok) continue;
                check("stop bit", {31'd0, Tx}, 32'd1);
                starts.push_back(st);
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected frame: got %0h expected none", d);
                end else begin
                    check("frame byte", {24'd0, d}, {24'd0, sb.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy !== 1'b0 && n < 20000) begin
            @(negedge Clk);
            n++;
        end
        check("idle reached", {31'd0, n < 20000}, 32'd1);
        @(negedge Clk);
    endtask

    // burst on consecutive cycles starting from idle: DEPTH+1 fit, anything later drops
    task automatic burst(input logic [7:0] bs[$], input bit clr_drop);
        for (int i = 0; i < bs.size(); i++) begin
            @(negedge Clk);
            check("ready at strobe", {31'd0, Ready}, {31'd0, i <= DEPTH});
            Valid  = 1'b1;
            C      = bs[i];
            OvfClr = clr_drop && (i > DEPTH);
            if (i <= DEPTH) sb.push_back(bs[i]);
        end
        @(negedge Clk);
        Valid  = 1'b0;
        OvfClr = 1'b0;
        check("overflow after burst", {31'd0, Overflow},
              {31'd0, (bs.size() > DEPTH + 1) && !clr_drop});
    endtask

    task automatic idle_line(input string name);
        int lows = 0;
        repeat (100) begin
            @(negedge Clk);
            if (Tx !== 1'b1) lows++;
        end
        check(name, lows, 0);
    endtask

    initial begin : stim
        logic [7:0] q[$];
        int s0, n, len;

        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("reset Tx", {31'd0, Tx}, 32'd1);
        check("reset Ready", {31'd0, Ready}, 32'd1);
        check("reset Busy", {31'd0, Busy}, 32'd0);
        check("reset Overflow", {31'd0, Overflow}, 32'd0);
        idle_line("idle after reset");

        // single byte 8'h03
        @(negedge Clk);
        Valid = 1'b1;
        C = 8'h03;
        sb.push_back(8'h03);
        @(negedge Clk);
        Valid = 1'b0;
        check("busy on accept", {31'd0, Busy}, 32'd1);
        check("tx before start", {31'd0, Tx}, 32'd1);
        @(negedge Clk);
        check("tx start edge", {31'd0, Tx}, 32'd0);
        n = 0;
        while (Busy === 1'b1 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check("busy fall after frame", n, FRAME);
        wait_idle();

`ifdef IPU_TX_PARITY_EN
        q = '{8'h07};
        burst(q, 1'b0);
        wait_idle();
`endif

        // back-to-back frames
        s0 = starts.size();
        q = '{8'hFF, 8'h02, 8'hA5};
        burst(q, 1'b0);
        wait_idle();
        check("b2b frame count", starts.size() - s0, 3);
        if (starts.size() >= s0 + 3) begin
            check("b2b gap 1", starts[s0 + 1] - starts[s0], FRAME);
            check("b2b gap 2", starts[s0 + 2] - starts[s0 + 1], FRAME);
        end

        // overflow with 6 strobes, then clear
        q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        burst(q, 1'b0);
        @(negedge Clk);
        OvfClr = 1'b1;
        @(negedge Clk);
        OvfClr = 1'b0;
        check("overflow cleared", {31'd0, Overflow}, 32'd0);
        wait_idle();

        // clear wins over a simultaneous drop
        q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        burst(q, 1'b1);
        wait_idle();

        // reset mid-frame during bit 4 of 8'h55
        @(negedge Clk);
        Valid = 1'b1;
        C = 8'h55;
        sb.push_back(8'h55);
        @(negedge Clk);
        Valid = 1'b0;
        @(negedge Clk);
        repeat (5 * CPB + CPB / 2) @(negedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        check("tx high in reset", {31'd0, Tx}, 32'd1);
        check("busy low in reset", {31'd0, Busy}, 32'd0);
        sb.delete();
        s0 = starts.size();
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        idle_line("idle after mid reset");
        check("no frame after reset", starts.size() - s0, 0);
        q = '{8'h5A};
        burst(q, 1'b0);
        wait_idle();

        // random bursts, each from idle
        for (int b = 0; b < 8; b++) begin
            len = $urandom_range(1, DEPTH + 1);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            burst(q, 1'($urandom_range(0, 1)));
            @(negedge Clk);
            OvfClr = 1'b1;
            @(negedge Clk);
            OvfClr = 1'b0;
            wait_idle();
        end

        repeat (5) @(negedge Clk);
        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
